seq_detect_ctrl: RTL and testbench

//  Programmable symbol-sequence match controller for the 3-bit symbol detector path. Holds a

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_pattern_regfile.sv | 54 +++++
 rtl/seq_detect_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_detect_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and reset defaults for the symbol-sequence detector.
// Default pattern is 001,101,110,000 with length 4.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_LEN = 4;

  localparam logic [DEFAULT_LEN-1:0][2:0] DEFAULT_PATTERN = {
    3'b000, 3'b110, 3'b101, 3'b001
  };

  function automatic logic [2:0] default_sym(input int i);
    logic [1:0] k;
    k = i[1:0];
    if (i >= 0 && i < DEFAULT_LEN) return DEFAULT_PATTERN[k];
    return 3'b000;
  endfunction

endpackage

// File: rtl/seq_pattern_regfile.sv
// Target pattern slots and length register; writable only while idle.
// Exposes the symbol at the current match index and the first symbol.
module seq_pattern_regfile
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             idle_i,
  input  logic             sym_we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             len_we_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [AW-1:0]    rd_idx_i,
  output logic [SYM_W-1:0] rd_sym_o,
  output logic [SYM_W-1:0] rd_first_o,
  output logic [LEN_W-1:0] len_o
);

  logic [SYM_W-1:0] pat_q [MAX_LEN];
  logic [LEN_W-1:0] len_q;
  logic             len_ok;

  // Out-of-range lengths are dropped so the register always holds 1..MAX_LEN
  assign len_ok = (len_i != '0) && (len_i <= LEN_W'(MAX_LEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        pat_q[i] <= SYM_W'(default_sym(i));
      end
    end else if (idle_i && sym_we_i) begin
      pat_q[addr_i] <= sym_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= LEN_W'(DEFAULT_LEN);
    end else if (idle_i && len_we_i && len_ok) begin
      len_q <= len_i;
    end
  end

  assign rd_sym_o   = pat_q[rd_idx_i];
  assign rd_first_o = pat_q[0];
  assign len_o      = len_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable symbol-sequence match controller: FSM, match index,
// registered match pulse and saturating match counter.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 3,
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int AW     = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_sym_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [SYM_W-1:0] cfg_sym,
  input  logic             cfg_len_we,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             arm,
  input  logic             disarm,
  input  logic             oneshot,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_data,
  output logic             in_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state_o
);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, os_q, os_d;

  logic [SYM_W-1:0] pat_idx, pat_first;
  logic [LEN_W-1:0] len_cur, step_len;
  logic             accept, arm_go, hit;

  seq_pattern_regfile #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .AW      (AW)
  ) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .idle_i     (state_q == IDLE),
    .sym_we_i   (cfg_sym_we),
    .addr_i     (cfg_addr),
    .sym_i      (cfg_sym),
    .len_we_i   (cfg_len_we),
    .len_i      (cfg_len),
    .rd_idx_i   (idx_q),
    .rd_sym_o   (pat_idx),
    .rd_first_o (pat_first),
    .len_o      (len_cur)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
      os_q    <= os_d;
    end
  end

  // A symbol arriving with arm/disarm is discarded: those reset progress
  always_comb begin
    accept   = in_valid & in_ready;
    arm_go   = arm & ~disarm;
    step_len = '0;
    if (in_data == pat_idx) begin
      step_len = LEN_W'(idx_q) + LEN_W'(1);
    end else if (in_data == pat_first) begin
      step_len = LEN_W'(1);
    end
    hit   = accept & ~arm & ~disarm & (step_len == len_cur);
    idx_d = idx_q;
    cnt_d = cnt_q;
    os_d  = os_q;
    if (arm_go) begin
      idx_d = '0;
      cnt_d = '0;
      os_d  = oneshot;
    end else if (accept) begin
      idx_d = hit ? '0 : AW'(step_len);
      if (hit && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (arm_go) state_d = ARMED;
      end
      ARMED: begin
        if (disarm) state_d = IDLE;
        else if (hit && os_q) state_d = DONE;
      end
      DONE: begin
        if (disarm) state_d = IDLE;
        else if (arm_go) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ARMED);
    match       = match_q;
    match_count = cnt_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: vector table, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_sym_we, cfg_len_we;
  logic [2:0] cfg_addr, cfg_sym, in_data;
  logic [3:0] cfg_len;
  logic       arm, disarm, oneshot, in_valid;
  logic       in_ready, match;
  logic [7:0] match_count;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_sym_we  (cfg_sym_we),
    .cfg_addr    (cfg_addr),
    .cfg_sym     (cfg_sym),
    .cfg_len_we  (cfg_len_we),
    .cfg_len     (cfg_len),
    .arm         (arm),
    .disarm      (disarm),
    .oneshot     (oneshot),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .match       (match),
    .match_count (match_count),
    .state_o     (state_o)
  );

  // Reference model: state 0=IDLE 1=ARMED 2=DONE; q holds the symbols
  // of the partial match in progress.
  int m_state, m_len, m_cnt;
  int m_pat [8];
  bit m_match, m_os;
  int q [$];

  function automatic void m_reset();
    m_state = 0;
    m_len   = 4;
    m_pat   = '{1, 5, 6, 0, 0, 0, 0, 0};
    m_cnt   = 0;
    m_match = 0;
    m_os    = 0;
    q.delete();
  endfunction

  function automatic void m_step();
    bit acc, was_idle, ok;
    acc      = in_valid && (m_state == 1);
    was_idle = (m_state == 0);
    m_match  = 0;
    if (disarm) begin
      m_state = 0;
    end else if (arm) begin
      m_state = 1;
      m_cnt   = 0;
      m_os    = oneshot;
      q.delete();
    end else if (acc) begin
      q.push_back(int'(in_data));
      ok = 1;
      foreach (q[i]) if (q[i] != m_pat[i]) ok = 0;
      if (!ok) begin
        q.delete();
        if (int'(in_data) == m_pat[0]) q.push_back(int'(in_data));
      end
      if (q.size() == m_len) begin
        m_match = 1;
        q.delete();
        if (m_cnt < 255) m_cnt++;
        if (m_os) m_state = 2;
      end
    end
    if (was_idle) begin
      if (cfg_sym_we) m_pat[cfg_addr] = int'(cfg_sym);
      if (cfg_len_we && cfg_len >= 1 && cfg_len <= 8) m_len = int'(cfg_len);
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [11:0] exp;
    m_step();
    @(posedge clk);
    #1;
    exp = {m_state == 1, m_match, m_cnt[7:0], m_state[1:0]};
    chk("model", {in_ready, match, match_count, state_o}, exp);
  endtask

  task automatic set_idle();
    cfg_sym_we = 0; cfg_len_we = 0; cfg_addr = 0; cfg_sym = 0; cfg_len = 0;
    arm = 0; disarm = 0; oneshot = 0; in_valid = 0; in_data = 0;
  endtask

  task automatic sym(input logic [2:0] d);
    in_valid = 1; in_data = d; step(); in_valid = 0;
  endtask

  task automatic do_arm(input bit os);
    arm = 1; oneshot = os; step(); arm = 0; oneshot = 0;
  endtask

  task automatic do_disarm();
    disarm = 1; step(); disarm = 0;
  endtask

  task automatic wr_sym(input logic [2:0] a, input logic [2:0] s);
    cfg_sym_we = 1; cfg_addr = a; cfg_sym = s; step(); cfg_sym_we = 0;
  endtask

  task automatic wr_len(input logic [3:0] l);
    cfg_len_we = 1; cfg_len = l; step(); cfg_len_we = 0;
  endtask

  typedef struct {
    bit         a;
    bit         v;
    logic [2:0] d;
    bit         em;
    int         ec;
    int         es;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1, 0, 3'b000, 0, 0, 1};
    tbl[1]  = '{0, 1, 3'b001, 0, 0, 1};
    tbl[2]  = '{0, 1, 3'b101, 0, 0, 1};
    tbl[3]  = '{0, 1, 3'b110, 0, 0, 1};
    tbl[4]  = '{0, 1, 3'b000, 1, 1, 1};
    tbl[5]  = '{0, 0, 3'b000, 0, 1, 1};
    tbl[6]  = '{1, 0, 3'b000, 0, 0, 1};
    tbl[7]  = '{0, 1, 3'b001, 0, 0, 1};
    tbl[8]  = '{0, 1, 3'b001, 0, 0, 1};
    tbl[9]  = '{0, 1, 3'b101, 0, 0, 1};
    tbl[10] = '{0, 1, 3'b110, 0, 0, 1};
    tbl[11] = '{0, 1, 3'b000, 1, 1, 1};
    tbl[12] = '{0, 0, 3'b000, 0, 1, 1};

    set_idle();
    reset_n = 0;
    m_reset();
    #12;
    chk("reset_state", {in_ready, match, match_count, state_o}, 12'h000);
    @(negedge clk);
    reset_n = 1;

    // Default pattern, then restart on a repeated first symbol
    for (int i = 0; i < 13; i++) begin
      arm = tbl[i].a; in_valid = tbl[i].v; in_data = tbl[i].d;
      step();
      chk($sformatf("tbl[%0d]", i), {match, match_count, state_o},
          {tbl[i].em, tbl[i].ec[7:0], tbl[i].es[1:0]});
    end
    set_idle();

    // Program len=2, 011,011 and run oneshot
    do_disarm();
    wr_len(4'd2);
    wr_sym(3'd0, 3'b011);
    wr_sym(3'd1, 3'b011);
    do_arm(1);
    sym(3'b011);
    sym(3'b011);
    chk("oneshot_match", {match, state_o, in_ready}, {1'b1, 2'd2, 1'b0});
    sym(3'b011);
    chk("done_no_accept", {match, match_count, state_o, in_ready},
        {1'b0, 8'd1, 2'd2, 1'b0});

    // Config writes while armed are ignored
    set_idle();
    reset_n = 0; #2; m_reset(); @(negedge clk); reset_n = 1;
    do_arm(0);
    wr_len(4'd1);
    wr_sym(3'd0, 3'b111);
    sym(3'b001);
    chk("armed_len_ignored", {match, match_count}, 9'd0);
    sym(3'b101);
    sym(3'b110);
    sym(3'b000);
    chk("armed_default_match", {match, match_count}, {1'b1, 8'd1});
    arm = 1; disarm = 1; step(); arm = 0; disarm = 0;
    chk("arm_disarm_idle", {state_o, in_ready}, {2'd0, 1'b0});

    // Reset in the middle of a partial match
    do_arm(0);
    sym(3'b001);
    sym(3'b101);
    sym(3'b110);
    reset_n = 0;
    #2;
    m_reset();
    chk("midreset", {match, match_count, state_o}, 11'd0);
    @(negedge clk);
    reset_n = 1;
    do_arm(0);
    sym(3'b000);
    chk("post_reset_lone", {match, match_count}, 9'd0);
    sym(3'b001);
    sym(3'b101);
    sym(3'b110);
    chk("post_reset_partial", match, 1'b0);
    sym(3'b000);
    chk("post_reset_len4", {match, match_count}, {1'b1, 8'd1});

    // Saturation with len=1
    do_disarm();
    wr_len(4'd1);
    wr_sym(3'd0, 3'b101);
    do_arm(0);
    for (int i = 0; i < 260; i++) begin
      sym(3'b101);
      chk("sat_pulse", match, 1'b1);
    end
    chk("sat_count", match_count, 8'd255);

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      do_disarm();
      if (r % 7 == 6) wr_len(4'($urandom_range(9, 15)));
      else wr_len(4'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) wr_sym(3'(k), 3'($urandom_range(0, 3)));
      do_arm(1'($urandom_range(0, 1)));
      for (int c = 0; c < 60; c++) begin
        in_valid   = ($urandom_range(0, 3) != 0);
        in_data    = 3'($urandom_range(0, 3));
        arm        = ($urandom_range(0, 39) == 0);
        disarm     = ($urandom_range(0, 59) == 0);
        oneshot    = 1'($urandom_range(0, 1));
        cfg_sym_we = ($urandom_range(0, 7) == 0);
        cfg_addr   = 3'($urandom_range(0, 7));
        cfg_sym    = 3'($urandom_range(0, 3));
        cfg_len_we = ($urandom_range(0, 7) == 0);
        cfg_len    = 4'($urandom_range(0, 15));
        step();
      end
      set_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
